// File: rtl/sky_pkg.sv
// Shared types and constants for the sky day/night sequencer.
package sky_pkg;

  typedef enum logic [1:0] {
    PH_DAY   = 2'd0,
    PH_DUSK  = 2'd1,
    PH_NIGHT = 2'd2,
    PH_DAWN  = 2'd3
  } phase_t;

  typedef logic [2:0] band_t;

  // Last scanline (inclusive) of each sky band; anything past BAND4_MAX is not sky.
  localparam int unsigned BAND0_MAX = 20;
  localparam int unsigned BAND1_MAX = 60;
  localparam int unsigned BAND2_MAX = 135;
  localparam int unsigned BAND3_MAX = 235;
  localparam int unsigned BAND4_MAX = 384;

  // Number of frames at the end of each phase spent crossfading to the next one.
  localparam int unsigned FADE_STEPS = 16;

  // 4:4:4 palettes, indexed [phase][band], band 0 at the top of the screen.
  localparam logic [11:0] SKY_PAL [4][5] = '{
    '{12'h138, 12'h04d, 12'h0af, 12'h3df, 12'haff},  // DAY
    '{12'h213, 12'h435, 12'h846, 12'hc64, 12'hf94},  // DUSK
    '{12'h001, 12'h002, 12'h013, 12'h024, 12'h035},  // NIGHT
    '{12'h124, 12'h346, 12'h869, 12'hca8, 12'hfdb}   // DAWN
  };

endpackage

// File: rtl/rgb444_blend.sv
// Combinational 4:4:4 crossfade: per channel (a*(16-k) + b*k) >> 4, truncated.
module rgb444_blend (
  input  logic [11:0] a,
  input  logic [11:0] b,
  input  logic [3:0]  k,
  output logic [11:0] rgb
);

  // Weighted sum of one 4-bit channel; the 8-bit sum peaks at 240 so it cannot wrap.
  function automatic logic [3:0] mix_ch(input logic [3:0] ca, input logic [3:0] cb,
                                        input logic [3:0] kk);
    logic [4:0] wa;
    logic [7:0] sum;
    wa  = 5'd16 - {1'b0, kk};
    sum = ({4'b0, ca} * {3'b0, wa}) + ({4'b0, cb} * {4'b0, kk});
    return sum[7:4];
  endfunction

  // Blend each channel independently.
  always_comb begin
    rgb[11:8] = mix_ch(a[11:8], b[11:8], k);
    rgb[7:4]  = mix_ch(a[7:4],  b[7:4],  k);
    rgb[3:0]  = mix_ch(a[3:0],  b[3:0],  k);
  end

endmodule

// File: rtl/sky_cycle_ctrl.sv
// Day/night sky sequencer: phase FSM with frame counter and crossfade level,
// plus a one-stage registered per-scanline palette lookup and blend.
module sky_cycle_ctrl
  import sky_pkg::*;
#(
  parameter int FRAMES_PER_PHASE = 600,
  parameter int Y_W              = 10
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           frame_tick,
  input  logic           pause,
  input  logic           restart,
  input  logic [Y_W-1:0] y,
  output logic [11:0]    sky_rgb,
  output logic           is_sky,
  output logic [1:0]     phase,
  output logic [3:0]     fade_level,
  output logic           night,
  output logic           phase_step
);

  localparam int FCNT_W = $clog2(FRAMES_PER_PHASE);
  localparam logic [FCNT_W-1:0] FCNT_LAST  = FCNT_W'(FRAMES_PER_PHASE - 1);
  localparam logic [FCNT_W-1:0] FADE_START = FCNT_W'(FRAMES_PER_PHASE - int'(FADE_STEPS));

  phase_t            phase_q, phase_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              step_q, step_d;
  logic              tick_ok;
  logic [3:0]        fade_w;
  logic              night_w;

  logic [31:0]       y_ext_p0;
  band_t             band_p0;
  logic              vld_p0;
  logic [1:0]        ph_nxt_p0;
  logic [11:0]       pal_cur_p0, pal_nxt_p0, mix_p0;
  logic [11:0]       rgb_p1;
  logic              vld_p1;

  // Maps a scanline to its sky band; callers gate the result with the sky flag.
  function automatic band_t band_of(input logic [31:0] yy);
    if (yy <= BAND0_MAX)      return 3'd0;
    else if (yy <= BAND1_MAX) return 3'd1;
    else if (yy <= BAND2_MAX) return 3'd2;
    else if (yy <= BAND3_MAX) return 3'd3;
    else                      return 3'd4;
  endfunction

  // A tick only counts when not frozen and not overridden by restart.
  assign tick_ok = frame_tick & ~pause & ~restart;

  // State register: phase, frame counter and the phase-advance pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= PH_DAY;
      fcnt_q  <= '0;
      step_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      fcnt_q  <= fcnt_d;
      step_q  <= step_d;
    end
  end

  // Next state: restart wins over a same-cycle tick; state otherwise holds all frame.
  always_comb begin
    phase_d = phase_q;
    fcnt_d  = fcnt_q;
    step_d  = 1'b0;
    if (restart) begin
      phase_d = PH_DAY;
      fcnt_d  = '0;
    end else if (tick_ok) begin
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d  = '0;
        phase_d = phase_t'(phase_q + 2'd1);
        step_d  = 1'b1;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Outputs decoded from the held state: fade ramps 0..15 over the last frames of a phase.
  always_comb begin
    fade_w  = 4'd0;
    night_w = (phase_q == PH_NIGHT);
    if (fcnt_q >= FADE_START) fade_w = 4'(fcnt_q - FADE_START);
  end

  assign phase      = phase_q;
  assign fade_level = fade_w;
  assign night      = night_w;
  assign phase_step = step_q;

  // ---- stage p0: band decode and palette fetch for the incoming scanline ----
  always_comb begin
    y_ext_p0   = 32'(y);
    vld_p0     = (y_ext_p0 <= BAND4_MAX);
    band_p0    = vld_p0 ? band_of(y_ext_p0) : 3'd0;
    ph_nxt_p0  = phase_q + 2'd1;
    pal_cur_p0 = SKY_PAL[phase_q][band_p0];
    pal_nxt_p0 = SKY_PAL[ph_nxt_p0][band_p0];
  end

  rgb444_blend u_blend (
    .a   (pal_cur_p0),
    .b   (pal_nxt_p0),
    .k   (fade_w),
    .rgb (mix_p0)
  );

  // ---- stage p1: registered pixel colour, black outside the sky region ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_p1 <= 12'h000;
      vld_p1 <= 1'b0;
    end else begin
      rgb_p1 <= vld_p0 ? mix_p0 : 12'h000;
      vld_p1 <= vld_p0;
    end
  end

  assign sky_rgb = rgb_p1;
  assign is_sky  = vld_p1;

endmodule

// File: tb/tb_sky_cycle_ctrl.sv
// Self-checking bench for sky_cycle_ctrl with a frame-count reference model.
module tb_sky_cycle_ctrl;

  localparam int FPP = 20;
  localparam int Y_W = 10;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           frame_tick, pause, restart;
  logic [Y_W-1:0] y;
  logic [11:0]    sky_rgb;
  logic           is_sky;
  logic [1:0]     phase;
  logic [3:0]     fade_level;
  logic           night;
  logic           phase_step;

  int n_checks = 0;
  int n_errs   = 0;

  // Model: accepted ticks since DAY/frame 0, modulo a whole day, plus the step pulse.
  int tot = 0;
  bit stp = 0;

  int pal [4][5] = '{
    '{'h138, 'h04d, 'h0af, 'h3df, 'haff},
    '{'h213, 'h435, 'h846, 'hc64, 'hf94},
    '{'h001, 'h002, 'h013, 'h024, 'h035},
    '{'h124, 'h346, 'h869, 'hca8, 'hfdb}
  };
  int band_top [5] = '{20, 60, 135, 235, 384};

  sky_cycle_ctrl #(.FRAMES_PER_PHASE(FPP), .Y_W(Y_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .pause      (pause),
    .restart    (restart),
    .y          (y),
    .sky_rgb    (sky_rgb),
    .is_sky     (is_sky),
    .phase      (phase),
    .fade_level (fade_level),
    .night      (night),
    .phase_step (phase_step)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_phase();
    return (tot / FPP) % 4;
  endfunction

  function automatic int m_fade();
    int f;
    f = tot % FPP;
    return (f >= FPP - 16) ? f - (FPP - 16) : 0;
  endfunction

  function automatic int exp_rgb(input int ph, input int k, input int yy);
    int b, a, n, r, ca, cb;
    if (yy > 384) return 0;
    b = 0;
    while (yy > band_top[b]) b++;
    a = pal[ph][b];
    n = pal[(ph + 1) % 4][b];
    r = 0;
    for (int c = 0; c < 3; c++) begin
      ca = (a >> (4 * c)) & 15;
      cb = (n >> (4 * c)) & 15;
      r |= ((ca * (16 - k) + cb * k) / 16) << (4 * c);
    end
    return r;
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_phase"}, 32'(phase), m_phase());
    check({tag, "_fade"},  32'(fade_level), m_fade());
    check({tag, "_night"}, 32'(night), (m_phase() == 2) ? 1 : 0);
    check({tag, "_step"},  32'(phase_step), stp ? 1 : 0);
  endtask

  // One clock: drive inputs, step the model, then compare every output.
  task automatic cycle(input bit tk, input bit ps, input bit rs, input int yy);
    int e_rgb, e_sky;
    frame_tick = tk;
    pause      = ps;
    restart    = rs;
    y          = yy[Y_W-1:0];
    e_rgb = exp_rgb(m_phase(), m_fade(), yy);
    e_sky = (yy <= 384) ? 1 : 0;
    @(posedge clk);
    #1;
    if (rs) begin
      tot = 0;
      stp = 0;
    end else if (tk && !ps) begin
      tot = (tot + 1) % (4 * FPP);
      stp = (tot % FPP) == 0;
    end else begin
      stp = 0;
    end
    frame_tick = 1'b0;
    restart    = 1'b0;
    check("rgb", 32'(sky_rgb), e_rgb);
    check("sky", 32'(is_sky), e_sky);
    check_state("st");
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rgb"},   32'(sky_rgb), 0);
    check({tag, "_sky"},   32'(is_sky), 0);
    check({tag, "_phase"}, 32'(phase), 0);
    check({tag, "_fade"},  32'(fade_level), 0);
    check({tag, "_night"}, 32'(night), 0);
    check({tag, "_step"},  32'(phase_step), 0);
  endtask

  int ys [5] = '{0, 20, 21, 384, 385};
  int er [5] = '{'h138, 'h138, 'h04d, 'haff, 'h000};
  int es [5] = '{1, 1, 1, 1, 0};

  initial begin
    reset_n = 1'b0; frame_tick = 1'b0; pause = 1'b0; restart = 1'b0; y = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset_n = 1'b1;

    // Reset and band boundaries
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, ys[i]);
      check("t1_rgb", 32'(sky_rgb), er[i]);
      check("t1_sky", 32'(is_sky), es[i]);
      check("t1_phase", 32'(phase), 0);
    end

    // Mid-fade blend
    repeat (12) cycle(1, 0, 0, 300);
    cycle(0, 0, 0, 0);
    check("t2_fade", 32'(fade_level), 8);
    check("t2_rgb", 32'(sky_rgb), 'h125);

    // Wrap into DUSK and a full day
    repeat (7) cycle(1, 0, 0, 100);
    cycle(1, 0, 0, 0);
    check("t3_phase20", 32'(phase), 1);
    check("t3_step20", 32'(phase_step), 1);
    check("t3_fade20", 32'(fade_level), 0);
    cycle(0, 0, 0, 0);
    check("t3_step_off", 32'(phase_step), 0);
    check("t3_rgb20", 32'(sky_rgb), 'h213);
    for (int t = 21; t <= 60; t++) begin
      cycle(1, 0, 0, (t * 37) % 400);
      if (t >= 40 && t <= 59) check("t3_night", 32'(night), 1);
    end
    check("t3_phase60", 32'(phase), 3);
    check("t3_night60", 32'(night), 0);
    repeat (20) cycle(1, 0, 0, 50);
    check("t3_phase80", 32'(phase), 0);

    // Pause freezes the sequencer
    cycle(0, 0, 1, 10);
    repeat (5) cycle(1, 0, 0, 10);
    repeat (10) cycle(1, 1, 0, 10);
    check("t4_fade", 32'(fade_level), 1);
    check("t4_phase", 32'(phase), 0);
    cycle(1, 0, 0, 10);
    check("t4_resume", 32'(fade_level), 2);

    // Restart colliding with the wrap tick in DUSK
    cycle(0, 0, 1, 0);
    repeat (39) cycle(1, 0, 0, 200);
    check("t5_pre_phase", 32'(phase), 1);
    check("t5_pre_fade", 32'(fade_level), 15);
    cycle(1, 0, 1, 0);
    check("t5_phase", 32'(phase), 0);
    check("t5_fade", 32'(fade_level), 0);
    check("t5_step", 32'(phase_step), 0);
    cycle(0, 0, 0, 0);
    check("t5_rgb", 32'(sky_rgb), 'h138);

    // Asynchronous reset in the middle of a fade
    cycle(0, 0, 1, 0);
    repeat (13) cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("t6_fade", 32'(fade_level), 10);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("t6");
    #2 reset_n = 1'b1;
    tot = 0;
    stp = 0;
    cycle(0, 0, 0, 0);
    check("t6_rgb", 32'(sky_rgb), 'h138);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 63) == 0), int'($urandom_range(0, 1023)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/sky_cycle_ctrl.md
# sky_cycle_ctrl

Day/night sequencer for the sky background renderer. It counts frames, steps through four sky palettes (DAY, DUSK, NIGHT, DAWN) and crossfades between them over the last 16 frames of each phase. For each scanline `y` it returns the band colour and the `is_sky` flag to the pixel compositor, in place of the fixed-palette sky lookup.

## Interface
- `FRAMES_PER_PHASE`, default 600: frames spent in each phase, including the fade. Must be ≥ 16.
- `Y_W`, default 10: width of the `y` coordinate.
- `clk  in  1`: pixel clock.
- `reset_n  in  1`: asynchronous reset, active-low.
- `frame_tick  in  1`: one-cycle pulse, once per frame at vblank start.
- `pause  in  1`: level signal. While high, `frame_tick` is ignored (game-over freeze).
- `restart  in  1`: one-cycle pulse. Forces DAY with the frame count at 0.
- `y  in  Y_W`: current scanline.
- `sky_rgb  out  12`: registered 4:4:4 colour for `y`.
- `is_sky  out  1`: registered; high when `y` lies in the sky region.
- `phase  out  2`: 0=DAY, 1=DUSK, 2=NIGHT, 3=DAWN.
- `fade_level  out  4`: current blend weight toward the next phase.
- `night  out  1`: high when `phase`==NIGHT, for sprite dimming.
- `phase_step  out  1`: one-cycle pulse on each phase advance.

## Operation
- **State machine:** DAY→DUSK→NIGHT→DAWN→DAY, strictly cyclic. There are no other transitions except `restart` and reset, both of which go to DAY.
- **Frame counter `fcnt`:** ceil(log2(FRAMES_PER_PHASE)) bits, range 0..FRAMES_PER_PHASE-1.
  - On an accepted tick (`frame_tick` & !`pause` & !`restart`): if `fcnt`==FRAMES_PER_PHASE-1, set `fcnt`=0, advance `phase` and pulse `phase_step`. Otherwise `fcnt`+1.
- **Fade level:** `fade_level` = 0 while `fcnt` < FRAMES_PER_PHASE-16. Otherwise it equals `fcnt`-(FRAMES_PER_PHASE-16), giving 0..15.
- **Band decode of `y`:**
  - 0–20 → band 0
  - 21–60 → band 1
  - 61–135 → band 2
  - 136–235 → band 3
  - 236–384 → band 4
  - y > 384: `is_sky`=0, `sky_rgb`=12'h000
- **Palettes, bands 0..4:**
  - DAY: 138, 04d, 0af, 3df, aff
  - DUSK: 213, 435, 846, c64, f94
  - NIGHT: 001, 002, 013, 024, 035
  - DAWN: 124, 346, 869, ca8, fdb
- **Blend:** a = current palette[band], b = next palette[band], k = `fade_level`.
  - Per 4-bit channel: out = (a·(16−k) + b·k) >> 4.
  - Products and sum are 8 bits unsigned and cannot overflow. Truncate, no rounding.
  - k=0 gives exactly a.
- **Tear-free updates:** `phase`, `fcnt` and `fade_level` change only on an accepted tick, `restart` or reset, never mid-frame otherwise.
- **Priority:** reset > `restart` > `frame_tick`.
  - `restart` together with `frame_tick`: result is DAY, `fcnt`=0, no `phase_step`.
  - `pause` with `restart`: `restart` still applies.

## Timing
- `sky_rgb` and `is_sky` are registered with latency 1: the value for `y` sampled at edge N appears after edge N.
- `phase`, `fade_level`, `night` and `phase_step` update on the edge following the accepted tick or `restart` pulse. `phase_step` is high for exactly that one cycle.
- The pixel output uses the phase/fade state held at the sampling edge. There is no bypass of a same-cycle tick.
- **Reset values (async assert, sync to `clk` on release):**
  - `phase`=DAY, `fcnt`=0, `fade_level`=0
  - `sky_rgb`=000, `is_sky`=0, `night`=0, `phase_step`=0
- **Reset mid-fade:** all state clears immediately. The first output after release is the pure DAY palette.

## Structure
- Package `sky_pkg`:
  - `phase_t` enum (2 bits)
  - band boundary constants (20, 60, 135, 235, 384)
  - `SKY_PAL[4][5]` 12-bit palette constant
  - `FADE_STEPS`=16
- One sub-module, `rgb444_blend`: combinational a, b, k → blended colour, one instance.
- `sky_cycle_ctrl` holds the FSM, `fcnt`, band decode and output registers.

## Test plan
Benches run with FRAMES_PER_PHASE=20.
1. **Reset and band boundaries.** Release reset, then drive `y`=0, 20, 21, 384, 385 on consecutive cycles. One cycle later each: `sky_rgb`=138, 138, 04d, aff, 000; `is_sky`=1, 1, 1, 1, 0; `phase`=0.
2. **Mid-fade blend.** Send 12 ticks, then `y`=0. Required: `fade_level`=8 and `sky_rgb`=125, the 138/213 blend at k=8.
3. **Wrap and full cycle.**
   - After 20 ticks: `phase`=1, `phase_step` pulses for 1 cycle, `fade_level`=0, `y`=0 gives 213.
   - After 60 ticks: `phase`=3 and `night`=0. Between ticks 40 and 59: `night`=1.
   - After 80 ticks: `phase`=0.
4. **Pause.** Send 5 ticks, then hold `pause`=1 and send 10 ticks. `fade_level` and `phase` stay unchanged. Release `pause`; the next tick advances `fcnt` by 1.
5. **Restart collision.** At `fcnt`=19 in DUSK, assert `restart` together with `frame_tick`. Required: `phase`=0, `fade_level`=0, no `phase_step`, `y`=0 gives 138.
6. **Reset mid-fade.** At `fade_level`=10, pulse `reset_n` low between clock edges. All outputs go to their reset values immediately, without waiting for a clock edge.
